// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the MINI_MIPS fetch PC sequencer.
// Holds the FSM state enum, next-PC select enum and default vectors.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    TRAP,
    RET,
    REDIR,
    HOLD,
    INC
  } sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between next-PC control, PC sequencer and I-memory.
// master: sequencer (drives pc/status); slave: control + memory side.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 32
);

  logic                fetch_ready;
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                call_valid;
  logic                ret_valid;
  logic                trap_valid;
  logic                halt;
  logic                resume;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_valid;
  logic                misaligned_err;
  logic                ras_empty;
  logic                ras_full;

  modport master (
    input  fetch_ready, stall,
    input  redirect_valid, redirect_target,
    input  call_valid, ret_valid,
    input  trap_valid, halt, resume,
    output pc, pc_valid, misaligned_err,
    output ras_empty, ras_full
  );

  modport slave (
    output fetch_ready, stall,
    output redirect_valid, redirect_target,
    output call_valid, ret_valid,
    output trap_valid, halt, resume,
    input  pc, pc_valid, misaligned_err,
    input  ras_empty, ras_full
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/top, empty/full flags.
// Ports: clk, rst_n, push_i, pop_i, data_i -> top_o, empty_o, full_o.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] SP_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] sp_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] wr_idx;
  logic          pop_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_MAX);
  assign top_o   = mem_q[sp_q];

  // pop+push replaces the top in place; a plain push
  // past full wraps onto the oldest slot
  assign wr_idx = pop_ok ? sp_q : sp_q + SP_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '1;
      cnt_q <= '0;
    end else if (push_i && !pop_ok) begin
      sp_q <= sp_q + SP_ONE;
      if (!full_o) cnt_q <= cnt_q + CNT_ONE;
    end else if (pop_ok && !push_i) begin
      sp_q  <= sp_q - SP_ONE;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT FSM, prioritised next-PC select.
// Ports: clk, reset_n, bus (pc_sequencer_if.master). RAS: PC_SEQ_RAS_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEF_TRAP_VECTOR),
  parameter int                  INSTR_BYTES  = 4,
  parameter int                  RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           reset_n,
  pc_sequencer_if.master bus
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] LOW  = PC_WIDTH'(INSTR_BYTES - 1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                vld_q, vld_d;
  logic                mis_q, mis_d;
  logic [PC_WIDTH-1:0] seq_pc, tgt, ret_tgt;
  logic                load, run;
  sel_e                sel;

  assign run    = (state_q == RUN);
  assign seq_pc = pc_q + STEP;

`ifdef PC_SEQ_RAS_EN
  logic                ras_push, ras_pop;
  logic                ras_emp, ras_ful;
  logic [PC_WIDTH-1:0] ras_top;

  assign ras_push = run && !bus.trap_valid
                 && bus.call_valid && bus.redirect_valid;
  assign ras_pop  = run && !bus.trap_valid && bus.ret_valid;
  // empty stack: a return falls back to the decoded target
  assign ret_tgt  = ras_emp ? bus.redirect_target : ras_top;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_WIDTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (seq_pc),
    .top_o   (ras_top),
    .empty_o (ras_emp),
    .full_o  (ras_ful)
  );

  assign bus.ras_empty = ras_emp;
  assign bus.ras_full  = ras_ful;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_call;

  assign unused_call   = bus.call_valid;
  assign ret_tgt       = bus.redirect_target;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
`endif

  // increments need an accepted request: pc_valid and fetch_ready
  always_comb begin
    sel = HOLD;
    priority case (1'b1)
      bus.trap_valid:            sel = TRAP;
      bus.ret_valid:             sel = RET;
      bus.redirect_valid:        sel = REDIR;
      bus.stall:                 sel = HOLD;
      bus.fetch_ready && vld_q:  sel = INC;
      default:                   sel = HOLD;
    endcase
  end

  always_comb begin
    tgt  = bus.redirect_target;
    load = 1'b1;
    unique case (sel)
      TRAP:    tgt  = TRAP_VECTOR;
      RET:     tgt  = ret_tgt;
      REDIR:   tgt  = bus.redirect_target;
      default: load = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (load) begin
          pc_d  = tgt & ~LOW;
          mis_d = |(tgt & LOW);
        end else if (sel == INC) begin
          pc_d = seq_pc;
        end
        if (bus.halt) state_d = HALT;
      end
      HALT: begin
        if (bus.trap_valid) begin
          state_d = RUN;
          pc_d    = TRAP_VECTOR & ~LOW;
          mis_d   = |(TRAP_VECTOR & LOW);
        end else if (bus.resume) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    // first RUN cycle after BOOT/HALT presents no request yet
    vld_d = run && (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_valid       = vld_q;
  assign bus.misaligned_err = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Covers both builds; RAS scenarios run when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt = 0;
  int   total = 0;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_WIDTH(32)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0080),
    .INSTR_BYTES  (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic idle();
    bus.fetch_ready     = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.call_valid      = 1'b0;
    bus.ret_valid       = 1'b0;
    bus.trap_valid      = 1'b0;
    bus.halt            = 1'b0;
    bus.resume          = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    bus.fetch_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.pc !== 32'h0)
      $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0);
    else pass_cnt++;
    total++;
    if (bus.pc_valid !== 1'b0)
      $display("FAIL reset_valid got=%b exp=0", bus.pc_valid);
    else pass_cnt++;
    total++;
    if (bus.misaligned_err !== 1'b0)
      $display("FAIL reset_mis got=%b exp=0", bus.misaligned_err);
    else pass_cnt++;
    total++;
    if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0)
      $display("FAIL reset_ras got=%b%b exp=10",
               bus.ras_empty, bus.ras_full);
    else pass_cnt++;
    reset_n = 1'b1;
    step();
    total++;
    if (bus.pc_valid !== 1'b0)
      $display("FAIL boot_edge1 got=%b exp=0", bus.pc_valid);
    else pass_cnt++;
    step();
    total++;
    if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h0)
      $display("FAIL boot_edge2 got=%b/%h exp=1/0",
               bus.pc_valid, bus.pc);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (bus.pc !== 32'(i * 4))
        $display("FAIL free_run got=%h exp=%h", bus.pc, 32'(i * 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    idle();
    bus.fetch_ready = 1'b1;
    step();
    total++;
    if (bus.pc !== 32'h10)
      $display("FAIL run_to_10 got=%h exp=10", bus.pc);
    else pass_cnt++;
    bus.stall = 1'b1;
    step();
    total++;
    if (bus.pc !== 32'h10)
      $display("FAIL stall_hold got=%h exp=10", bus.pc);
    else pass_cnt++;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    step();
    total++;
    if (bus.pc !== 32'h200)
      $display("FAIL stall_redir got=%h exp=200", bus.pc);
    else pass_cnt++;
    idle();
    step();
    total++;
    if (bus.pc !== 32'h200)
      $display("FAIL no_ready_hold got=%h exp=200", bus.pc);
    else pass_cnt++;
  endtask

  task automatic test_trap_priority();
    idle();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h400;
    bus.call_valid      = 1'b1;
    step();
    total++;
    if (bus.pc !== 32'h400 || bus.ras_empty !== !RAS_ON)
      $display("FAIL call_400 got=%h/%b exp=400/%b",
               bus.pc, bus.ras_empty, !RAS_ON);
    else pass_cnt++;
    bus.trap_valid      = 1'b1;
    bus.ret_valid       = 1'b1;
    bus.redirect_target = 32'h300;
    step();
    total++;
    if (bus.pc !== 32'h80 || bus.misaligned_err !== 1'b0)
      $display("FAIL trap_prio got=%h/%b exp=80/0",
               bus.pc, bus.misaligned_err);
    else pass_cnt++;
    total++;
    if (bus.ras_empty !== !RAS_ON || bus.ras_full !== 1'b0)
      $display("FAIL trap_ras got=%b%b exp=%b0",
               bus.ras_empty, bus.ras_full, !RAS_ON);
    else pass_cnt++;
    idle();
    bus.ret_valid       = 1'b1;
    bus.redirect_target = 32'h500;
    step();
    total++;
    if (bus.pc !== (RAS_ON ? 32'h204 : 32'h500))
      $display("FAIL ret_after_trap got=%h exp=%h",
               bus.pc, RAS_ON ? 32'h204 : 32'h500);
    else pass_cnt++;
    total++;
    if (bus.ras_empty !== 1'b1)
      $display("FAIL ret_empty got=%b exp=1", bus.ras_empty);
    else pass_cnt++;
  endtask

  task automatic test_misaligned_wrap();
    idle();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h103;
    step();
    total++;
    if (bus.pc !== 32'h100 || bus.misaligned_err !== 1'b1)
      $display("FAIL misal_load got=%h/%b exp=100/1",
               bus.pc, bus.misaligned_err);
    else pass_cnt++;
    idle();
    step();
    total++;
    if (bus.pc !== 32'h100 || bus.misaligned_err !== 1'b0)
      $display("FAIL misal_pulse got=%h/%b exp=100/0",
               bus.pc, bus.misaligned_err);
    else pass_cnt++;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    total++;
    if (bus.pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_load got=%h exp=fffffffc", bus.pc);
    else pass_cnt++;
    idle();
    bus.fetch_ready = 1'b1;
    step();
    total++;
    if (bus.pc !== 32'h0)
      $display("FAIL wrap_zero got=%h exp=0", bus.pc);
    else pass_cnt++;
    step();
    total++;
    if (bus.pc !== 32'h4)
      $display("FAIL wrap_next got=%h exp=4", bus.pc);
    else pass_cnt++;
  endtask

`ifdef PC_SEQ_RAS_EN
  task automatic test_ras();
    logic [31:0] exp;
    idle();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h10;
    step();
    for (int i = 1; i <= 5; i++) begin
      bus.call_valid      = 1'b1;
      bus.redirect_target = 32'((i + 1) * 16);
      step();
      total++;
      if (bus.pc !== 32'((i + 1) * 16))
        $display("FAIL ras_call got=%h exp=%h",
                 bus.pc, 32'((i + 1) * 16));
      else pass_cnt++;
    end
    total++;
    if (bus.ras_full !== 1'b1 || bus.ras_empty !== 1'b0)
      $display("FAIL ras_full got=%b%b exp=10",
               bus.ras_full, bus.ras_empty);
    else pass_cnt++;
    idle();
    bus.ret_valid       = 1'b1;
    bus.redirect_target = 32'h700;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h54 - 32'(i * 16);
      step();
      total++;
      if (bus.pc !== exp)
        $display("FAIL ras_ret got=%h exp=%h", bus.pc, exp);
      else pass_cnt++;
    end
    total++;
    if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0)
      $display("FAIL ras_drained got=%b%b exp=10",
               bus.ras_empty, bus.ras_full);
    else pass_cnt++;
    step();
    total++;
    if (bus.pc !== 32'h700)
      $display("FAIL ras_underflow got=%h exp=700", bus.pc);
    else pass_cnt++;
    idle();
  endtask
`else
  task automatic test_no_ras();
    idle();
    bus.redirect_valid  = 1'b1;
    bus.call_valid      = 1'b1;
    bus.redirect_target = 32'h10;
    step();
    total++;
    if (bus.pc !== 32'h10 || bus.ras_empty !== 1'b1
        || bus.ras_full !== 1'b0)
      $display("FAIL noras_call got=%h/%b%b exp=10/10",
               bus.pc, bus.ras_empty, bus.ras_full);
    else pass_cnt++;
    idle();
    bus.ret_valid       = 1'b1;
    bus.redirect_target = 32'h604;
    step();
    total++;
    if (bus.pc !== 32'h604)
      $display("FAIL noras_ret got=%h exp=604", bus.pc);
    else pass_cnt++;
    bus.redirect_target = 32'h60A;
    step();
    total++;
    if (bus.pc !== 32'h608 || bus.misaligned_err !== 1'b1)
      $display("FAIL noras_misret got=%h/%b exp=608/1",
               bus.pc, bus.misaligned_err);
    else pass_cnt++;
    idle();
  endtask
`endif

  task automatic test_halt();
    idle();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h3C;
    step();
    idle();
    bus.fetch_ready = 1'b1;
    step();
    total++;
    if (bus.pc !== 32'h40)
      $display("FAIL pre_halt got=%h exp=40", bus.pc);
    else pass_cnt++;
    bus.halt = 1'b1;
    step();
    total++;
    if (bus.pc_valid !== 1'b0 || bus.pc !== 32'h44)
      $display("FAIL halt_enter got=%b/%h exp=0/44",
               bus.pc_valid, bus.pc);
    else pass_cnt++;
    bus.halt            = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h900;
    bus.ret_valid       = 1'b1;
    step();
    step();
    total++;
    if (bus.pc_valid !== 1'b0 || bus.pc !== 32'h44)
      $display("FAIL halt_frozen got=%b/%h exp=0/44",
               bus.pc_valid, bus.pc);
    else pass_cnt++;
    idle();
    bus.fetch_ready = 1'b1;
    bus.resume      = 1'b1;
    step();
    bus.resume = 1'b0;
    step();
    total++;
    if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h44)
      $display("FAIL resume got=%b/%h exp=1/44",
               bus.pc_valid, bus.pc);
    else pass_cnt++;
    step();
    total++;
    if (bus.pc !== 32'h48)
      $display("FAIL resume_adv got=%h exp=48", bus.pc);
    else pass_cnt++;
    bus.fetch_ready = 1'b0;
    bus.halt        = 1'b1;
    step();
    bus.halt       = 1'b0;
    bus.trap_valid = 1'b1;
    step();
    total++;
    if (bus.pc !== 32'h80)
      $display("FAIL halt_trap got=%h exp=80", bus.pc);
    else pass_cnt++;
    bus.trap_valid = 1'b0;
    step();
    total++;
    if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h80)
      $display("FAIL trap_run got=%b/%h exp=1/80",
               bus.pc_valid, bus.pc);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    idle();
    bus.redirect_valid  = 1'b1;
    bus.call_valid      = 1'b1;
    bus.redirect_target = 32'h500;
    step();
    total++;
    if (bus.pc !== 32'h500 || bus.ras_empty !== !RAS_ON)
      $display("FAIL pre_reset got=%h/%b exp=500/%b",
               bus.pc, bus.ras_empty, !RAS_ON);
    else pass_cnt++;
    idle();
    bus.fetch_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0
        || bus.ras_empty !== 1'b1)
      $display("FAIL async_reset got=%h/%b/%b exp=0/0/1",
               bus.pc, bus.pc_valid, bus.ras_empty);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total++;
    if (bus.pc_valid !== 1'b0 || bus.pc !== 32'h0)
      $display("FAIL reboot1 got=%b/%h exp=0/0",
               bus.pc_valid, bus.pc);
    else pass_cnt++;
    step();
    step();
    total++;
    if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h4)
      $display("FAIL reboot_run got=%b/%h exp=1/4",
               bus.pc_valid, bus.pc);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_trap_priority();
    test_misaligned_wrap();
`ifdef PC_SEQ_RAS_EN
    test_ras();
`else
    test_no_ras();
`endif
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
